// File: rtl/spi_ram_ctrl.sv
// Command-decoded single-port RAM behind the SPI slave shift register.
// Ports: clk/rst (sync, active-high), din/rx_valid/rx_ready command in,
// dout/tx_valid/tx_ready read data out, busy (fill running), err (sticky).
module spi_ram_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH+2:0] din,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  localparam logic [2:0] OP_SET_WADDR = 3'b000;
  localparam logic [2:0] OP_WRITE     = 3'b001;
  localparam logic [2:0] OP_SET_RADDR = 3'b010;
  localparam logic [2:0] OP_READ      = 3'b011;
  localparam logic [2:0] OP_SET_MODE  = 3'b100;
  localparam logic [2:0] OP_FILL      = 3'b101;

  localparam logic [ADDR_WIDTH-1:0] A_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_LAST = '1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  ainc;
  logic [DATA_WIDTH-1:0] fill_data;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] payload;
  logic [ADDR_WIDTH-1:0] addr_pl;
  logic                  accept;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign op       = din[DATA_WIDTH+2:DATA_WIDTH];
  assign payload  = din[DATA_WIDTH-1:0];
  assign addr_pl  = din[ADDR_WIDTH-1:0];
  assign rx_ready = !rst && (state == IDLE) && !tx_valid;
  assign accept   = rx_valid && rx_ready;
  assign busy     = (state == FILL);

  // Reset must also stop a fill write landing on the reset edge.
  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = payload;
    if (!rst) begin
      if (state == FILL) begin
        mem_we    = 1'b1;
        mem_wdata = fill_data;
      end else if (accept && op == OP_WRITE) begin
        mem_we = 1'b1;
      end
    end
  end

  // Storage is left unreset so it maps onto a plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_addr   <= '0;
      rd_addr   <= '0;
      ainc      <= 1'b0;
      fill_data <= '0;
      dout      <= '0;
      tx_valid  <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (tx_valid && tx_ready) tx_valid <= 1'b0;
      if (state == FILL) begin
        wr_addr <= wr_addr + A_ONE;
        if (wr_addr == A_LAST) state <= IDLE;
      end else if (accept) begin
        unique case (op)
          OP_SET_WADDR: wr_addr <= addr_pl;
          OP_WRITE: begin
            if (ainc) wr_addr <= wr_addr + A_ONE;
          end
          OP_SET_RADDR: rd_addr <= addr_pl;
          OP_READ: begin
            dout     <= mem[rd_addr];
            tx_valid <= 1'b1;
            if (ainc) rd_addr <= rd_addr + A_ONE;
          end
          OP_SET_MODE: ainc <= payload[0];
          OP_FILL: begin
            fill_data <= payload;
            state     <= FILL;
          end
          default: err <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl with a read-data scoreboard.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_spi_ram_ctrl;

  logic        clk;
  logic        rst;
  logic [10:0] din;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  dout;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        err;

  int pass_cnt = 0;
  int total    = 0;
  logic [7:0] sb_q[$];

  spi_ram_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .din(din), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .dout(dout), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cmd(input logic [2:0] op, input logic [7:0] pl);
    int n = 0;
    while (rx_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("rx_ready_timeout", 32'(rx_ready), 1);
    din      = {op, pl};
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic take(input string tag);
    int n = 0;
    logic [7:0] e;
    while (tx_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_txv"}, 32'(tx_valid), 1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb_q.size()), 1);
    end else begin
      e = sb_q.pop_front();
      chk(tag, 32'(dout), 32'(e));
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] e);
    sb_q.push_back(e);
    cmd(3'b011, 8'h00);
    take(tag);
  endtask

  initial begin
    logic [7:0] held;
    int n;
    rst      = 1'b1;
    din      = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rx_ready", 32'(rx_ready), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rx_ready", 32'(rx_ready), 1);

    // basic write/read with held response
    cmd(3'b000, 8'h10);
    cmd(3'b001, 8'hA5);
    cmd(3'b010, 8'h10);
    sb_q.push_back(8'hA5);
    cmd(3'b011, 8'h00);
    chk("basic_txv", 32'(tx_valid), 1);
    held = sb_q.pop_front();
    chk("basic_dout", 32'(dout), 32'(held));
    repeat (5) begin
      @(negedge clk);
      chk("hold_txv", 32'(tx_valid), 1);
      chk("hold_dout", 32'(dout), 32'(held));
      chk("hold_rx_ready", 32'(rx_ready), 0);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    chk("hs_txv", 32'(tx_valid), 0);
    chk("hs_dout_kept", 32'(dout), 8'hA5);
    chk("hs_rx_ready", 32'(rx_ready), 1);

    // auto-increment with wrap
    cmd(3'b100, 8'h01);
    cmd(3'b000, 8'hFE);
    cmd(3'b001, 8'h11);
    cmd(3'b001, 8'h22);
    cmd(3'b001, 8'h33);
    cmd(3'b010, 8'hFE);
    rd("ainc_rd0", 8'h11);
    rd("ainc_rd1", 8'h22);
    rd("ainc_rd2", 8'h33);
    // only bit 0 of the mode payload matters
    cmd(3'b100, 8'hFE);
    cmd(3'b010, 8'hFE);
    rd("noinc_rd0", 8'h11);
    rd("noinc_rd1", 8'h11);

    // back-to-back write then read
    cmd(3'b000, 8'h40);
    cmd(3'b010, 8'h40);
    cmd(3'b001, 8'h5A);
    rd("b2b_rd", 8'h5A);

    // fill with ignored rx_valid pulses
    cmd(3'b000, 8'hEF);
    cmd(3'b001, 8'h55);
    cmd(3'b000, 8'hF0);
    cmd(3'b101, 8'hC3);
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      chk("fill_rx_ready", 32'(rx_ready), 0);
      din      = {3'b001, 8'hEE};
      rx_valid = (n < 8);
      n++;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    chk("fill_cycles", 32'(n), 16);
    chk("fill_done_rx_ready", 32'(rx_ready), 1);
    cmd(3'b001, 8'h66);
    cmd(3'b100, 8'h01);
    cmd(3'b010, 8'hEF);
    rd("fill_below", 8'h55);
    for (int i = 0; i < 16; i++) rd("fill_data", 8'hC3);
    rd("fill_next_wr", 8'h66);
    cmd(3'b100, 8'h00);

    // illegal opcodes
    chk("err_clear", 32'(err), 0);
    cmd(3'b000, 8'h20);
    cmd(3'b010, 8'h20);
    cmd(3'b001, 8'hAB);
    cmd(3'b110, 8'h12);
    chk("err_set", 32'(err), 1);
    cmd(3'b111, 8'h34);
    rd("illegal_nochange", 8'hAB);
    cmd(3'b001, 8'hCD);
    rd("illegal_ptrs", 8'hCD);
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'(err), 1);

    // reset five cycles into a fill
    cmd(3'b000, 8'h05);
    cmd(3'b001, 8'h99);
    cmd(3'b000, 8'h00);
    cmd(3'b101, 8'h77);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstfill_busy", 32'(busy), 0);
    chk("rstfill_txv", 32'(tx_valid), 0);
    chk("rstfill_err", 32'(err), 0);
    rst = 1'b0;
    @(negedge clk);
    cmd(3'b100, 8'h01);
    cmd(3'b010, 8'h00);
    for (int i = 0; i < 5; i++) rd("rstfill_data", 8'h77);
    rd("rstfill_kept", 8'h99);

    // reset while a response is pending
    cmd(3'b010, 8'h00);
    cmd(3'b011, 8'h00);
    chk("pend_txv", 32'(tx_valid), 1);
    chk("pend_dout", 32'(dout), 8'h77);
    rst = 1'b1;
    @(negedge clk);
    chk("rsttx_txv", 32'(tx_valid), 0);
    chk("rsttx_dout", 32'(dout), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
